// File: rtl/rr_grant_scheduler_8.sv
// rr_grant_scheduler_8: round-robin scheduler that holds one grant among N_REQ requesters until done or abort.
// Define SCHED_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles and pulse timeout.

module rr_grant_scheduler_8_lane #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3,
  parameter int LANE  = 0
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             cand,
  output logic [IDX_W-1:0] idx
);
  // N_REQ is a power of two, so the IDX_W-bit add wraps modulo N_REQ
  assign idx  = ptr + IDX_W'(LANE);
  assign cand = req[idx];
endmodule

module rr_grant_scheduler_8 #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            ptr;
  logic [N_REQ-1:0]            lane_cand;
  logic [N_REQ-1:0][IDX_W-1:0] lane_idx;
  logic [IDX_W-1:0]            win_idx;
  logic                        rel;
  logic                        expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_grant_scheduler_8: MAX_HOLD must be within 2..255");
  end

  // Lane k looks at requester (ptr + k), i.e. the k-th slot of the scan order
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    rr_grant_scheduler_8_lane #(
      .N_REQ(N_REQ),
      .IDX_W(IDX_W),
      .LANE (g)
    ) u_lane (
      .req (req),
      .ptr (ptr),
      .cand(lane_cand[g]),
      .idx (lane_idx[g])
    );
  end

  always_comb begin
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (lane_cand[k]) win_idx = lane_idx[k];
  end

  assign rel = done || !req[grant_idx];

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  assign expire = (hold_cnt == HOLD_LAST);
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
`ifdef SCHED_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef SCHED_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en && |req) begin
            state       <= BUSY;
            grant       <= N_REQ'(1) << win_idx;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          // A real release takes precedence over the hold limit
          if (rel || expire) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + IDX_W'(1);
`ifdef SCHED_TIMEOUT_EN
            timeout     <= expire && !rel;
`endif
          end else begin
`ifdef SCHED_TIMEOUT_EN
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_scheduler_8.sv
// Bench for rr_grant_scheduler_8: directed scenarios then random traffic against a behavioural model.
module tb_rr_grant_scheduler_8;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, done;
  logic [7:0] req, grant;
  logic [2:0] grant_idx;
  logic       grant_valid, timeout;

  int n_vec = 0, n_err = 0;
  int m_own = -1, m_ptr = 0, m_hold = 0;
  bit m_to = 1'b0;
  int wait_cnt[8];

  rr_grant_scheduler_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: owner = -1 when idle; winner is the first requester scanning from ptr
  task automatic model(input bit r, input bit e, input logic [7:0] q, input bit d);
    bit rel, lim;
    if (!r) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_own < 0) begin
      if (e && q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (q[(m_ptr + k) % 8]) begin
            m_own = (m_ptr + k) % 8;
            break;
          end
        end
        m_hold = 0;
      end
    end else begin
      rel = d || !q[m_own];
`ifdef SCHED_TIMEOUT_EN
      lim = (m_hold == MAX_HOLD - 1);
`else
      lim = 1'b0;
`endif
      if (rel || lim) begin
        m_ptr  = (m_own + 1) % 8;
        m_to   = lim && !rel;
        m_own  = -1;
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit d);
    logic was_valid;
    bit   starved;
    was_valid = grant_valid;
    rst_n = r; en = e; req = q; done = d;
    model(r, e, q, d);
    @(posedge clk);
    @(negedge clk);
    chk("grant",       grant,       (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("grant_idx",   grant_idx,   (m_own < 0) ? 32'd0 : 32'(m_own));
    chk("grant_valid", grant_valid, 32'(m_own >= 0));
    chk("timeout",     timeout,     32'(m_to));
    chk("onehot0",     32'($onehot0(grant)), 32'd1);
    if (grant_valid) chk("idx_encode", grant, 32'd1 << grant_idx);
    if (!r) begin
      for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    end else if (!was_valid && grant_valid) begin
      starved = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i == int'(grant_idx) || !q[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (wait_cnt[i] > 8) starved = 1'b1;
      end
      chk("no_starve", 32'(starved), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rq;
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; done = 1'b0;

    // reset with every requester active
    cyc(0, 1, 8'hFF, 0);
    cyc(0, 1, 8'hFF, 0);
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", grant_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);

    // priority from ptr=0
    cyc(1, 1, 8'hA0, 0);
    chk("prio_grant", grant, 8'h20);
    chk("prio_idx", grant_idx, 3'd5);
    cyc(1, 1, 8'hA0, 1);
    chk("bubble_valid", grant_valid, 1'b0);
    cyc(1, 1, 8'hA0, 0);
    chk("next_grant", grant, 8'h80);
    chk("next_idx", grant_idx, 3'd7);

    // wrap 7 -> 0
    cyc(1, 1, 8'h81, 1);
    cyc(1, 1, 8'h81, 0);
    chk("wrap_grant", grant, 8'h01);
    chk("wrap_idx", grant_idx, 3'd0);

    // abort by owner 2 leaves ptr at 3
    cyc(1, 1, 8'h81, 1);
    cyc(1, 1, 8'h04, 0);
    chk("abort_own", grant_idx, 3'd2);
    cyc(1, 1, 8'h00, 0);
    chk("abort_rel", grant_valid, 1'b0);
    cyc(1, 1, 8'h0C, 0);
    chk("abort_ptr", grant, 8'h08);

    // en=0 blocks new grants
    cyc(1, 0, 8'hFF, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 8'hFF, 0);
      chk("en_block", grant_valid, 1'b0);
    end
    cyc(1, 1, 8'hFF, 0);
    chk("en_resume", grant, 8'h10);

`ifdef SCHED_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      cyc(1, 1, 8'hFF, 0);
      chk("hold_valid", grant_valid, 1'b1);
    end
    cyc(1, 1, 8'hFF, 0);
    chk("to_revoke", grant_valid, 1'b0);
    chk("to_pulse", timeout, 1'b1);
    cyc(1, 1, 8'hFF, 0);
    chk("to_clear", timeout, 1'b0);
    chk("to_next", grant_idx, 3'd5);
`else
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'hFF, 0);
    chk("hold_forever", grant_idx, 3'd4);
    chk("no_timeout", timeout, 1'b0);
`endif
    cyc(1, 1, 8'hFF, 1);

    // random traffic
    rq = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      rq = rq ^ 8'($urandom & $urandom & $urandom);
      cyc($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0, rq, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
